// File: rtl/bcd_updown_cnt_if.sv
// bcd_updown_cnt_if: control/data bundle for the multi-digit BCD up/down counter
//   master drives inc, dec, clr, load, load_val, sat; observes q, max, min, load_err
//   slave  (the counter) receives the requests and returns count and status
interface bcd_updown_cnt_if #(
   parameter int DIGITS = 3
);
   logic                  inc;
   logic                  dec;
   logic                  clr;
   logic                  load;
   logic                  sat;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   q;
   logic                  max;
   logic                  min;
   logic                  load_err;
   modport master (
      output inc, dec, clr, load, load_val, sat,
      input  q, max, min, load_err
   );
   modport slave (
      input  inc, dec, clr, load, load_val, sat,
      output q, max, min, load_err
   );
endinterface

// File: rtl/bcd_updown_cnt.sv
// bcd_updown_cnt: DIGITS-digit BCD up/down counter over 0..LIMIT with load, clear, wrap/saturate
//   CLK, RSTN (async active-low) plain ports; bus (slave): inc/dec step, clr, load/load_val,
//   sat mode, registered q and load_err, combinational cascade outputs max/min
module bcd_updown_cnt #(
   parameter int DIGITS = 3,
   parameter int LIMIT  = 499
) (
   input logic               CLK,
   input logic               RSTN,
   bcd_updown_cnt_if.slave   bus
);
   localparam int W = 4 * DIGITS;
   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int           t;
      r = '0;
      t = v;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction
   localparam logic [W-1:0] LIM = to_bcd(LIMIT);
   logic [W-1:0] q, q_inc, q_dec, q_nxt;
   logic         err, err_nxt;
   logic         up, down, at_lim, at_zero, dig_ok, ld_ok;
   logic         cy, bw;
   assign up      = bus.inc & ~bus.dec;
   assign down    = bus.dec & ~bus.inc;
   assign at_lim  = (q == LIM);
   assign at_zero = (q == '0);
   // Single-cycle ripple: a digit moves only while every lower digit is at its roll-over value
   always_comb begin
      cy    = 1'b1;
      bw    = 1'b1;
      q_inc = q;
      q_dec = q;
      for (int k = 0; k < DIGITS; k++) begin
         q_inc[4*k +: 4] = cy ? ((q[4*k +: 4] == 4'd9) ? 4'd0 : q[4*k +: 4] + 4'd1) : q[4*k +: 4];
         q_dec[4*k +: 4] = bw ? ((q[4*k +: 4] == 4'd0) ? 4'd9 : q[4*k +: 4] - 4'd1) : q[4*k +: 4];
         cy = cy & (q[4*k +: 4] == 4'd9);
         bw = bw & (q[4*k +: 4] == 4'd0);
      end
   end
   // With every digit legal, BCD compares the same as the decimal value, so a plain <= suffices
   always_comb begin
      dig_ok = 1'b1;
      for (int k = 0; k < DIGITS; k++)
         dig_ok = dig_ok & (bus.load_val[4*k +: 4] <= 4'd9);
   end
   assign ld_ok = dig_ok & (bus.load_val <= LIM);
   always_comb begin
      q_nxt   = bus.clr  ? '0 :
                bus.load ? (ld_ok ? bus.load_val : q) :
                up       ? (at_lim  ? (bus.sat ? q : '0)  : q_inc) :
                down     ? (at_zero ? (bus.sat ? q : LIM) : q_dec) : q;
      err_nxt = bus.clr ? 1'b0 : bus.load ? ~ld_ok : err;
   end
   always_ff @(posedge CLK or negedge RSTN)
      if (!RSTN) begin
         q   <= '0;
         err <= 1'b0;
      end else begin
         q   <= q_nxt;
         err <= err_nxt;
      end
   assign bus.q        = q;
   assign bus.load_err = err;
   assign bus.max      = up   & at_lim  & ~bus.clr & ~bus.load;
   assign bus.min      = down & at_zero & ~bus.clr & ~bus.load;
endmodule

// File: tb/tb_bcd_updown_cnt.sv
// tb_bcd_updown_cnt: directed self-checking bench for bcd_updown_cnt (DIGITS=3, LIMIT=499)
module tb_bcd_updown_cnt;
   logic CLK = 1'b0;
   logic RSTN = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   always #5 CLK = ~CLK;
   bcd_updown_cnt_if #(.DIGITS(3)) bus ();
   bcd_updown_cnt #(.DIGITS(3), .LIMIT(499)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));
   function automatic logic [11:0] tb_bcd(input int v);
      logic [11:0] r;
      r[11:8] = 4'(v / 100);
      r[7:4]  = 4'((v / 10) % 10);
      r[3:0]  = 4'(v % 10);
      return r;
   endfunction
   task automatic drive(input logic i, input logic d, input logic c, input logic l,
                        input logic [11:0] v, input logic s);
      bus.inc = i; bus.dec = d; bus.clr = c; bus.load = l; bus.load_val = v; bus.sat = s;
   endtask
   task automatic tick;
      @(posedge CLK);
      #1;
   endtask
   task automatic test_reset;
      drive(0, 0, 0, 0, 12'h000, 0);
      RSTN = 1'b0;
      #12;
      n_chk++; if (bus.q !== 12'h000) begin n_fail++; $display("FAIL reset_q got %h exp 000", bus.q); end
      n_chk++; if (bus.load_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.load_err); end
      n_chk++; if (bus.max !== 1'b0 || bus.min !== 1'b0) begin n_fail++; $display("FAIL reset_maxmin got %b%b exp 00", bus.max, bus.min); end
      drive(0, 1, 0, 0, 12'h000, 0);
      #1;
      n_chk++; if (bus.min !== 1'b1) begin n_fail++; $display("FAIL reset_min_eq got %b exp 1", bus.min); end
      drive(0, 0, 0, 0, 12'h000, 0);
      @(negedge CLK);
      RSTN = 1'b1;
   endtask
   task automatic test_count_up;
      int e;
      e = 0;
      drive(1, 0, 0, 0, 12'h000, 0);
      #1;
      repeat (500) begin
         n_chk++; if (bus.max !== (e == 499)) begin n_fail++; $display("FAIL up_max at %0d got %b exp %b", e, bus.max, (e == 499)); end
         tick();
         e = (e + 1) % 500;
         n_chk++; if (bus.q !== tb_bcd(e)) begin n_fail++; $display("FAIL up_q got %h exp %h", bus.q, tb_bcd(e)); end
      end
   endtask
   task automatic test_wrap_sat;
      drive(0, 1, 0, 0, 12'h000, 0);
      #1;
      n_chk++; if (bus.min !== 1'b1 || bus.max !== 1'b0) begin n_fail++; $display("FAIL wrap_min got %b%b exp 01", bus.max, bus.min); end
      tick();
      n_chk++; if (bus.q !== 12'h499) begin n_fail++; $display("FAIL wrap_down_q got %h exp 499", bus.q); end
      drive(1, 0, 0, 0, 12'h000, 0);
      tick();
      n_chk++; if (bus.q !== 12'h000) begin n_fail++; $display("FAIL wrap_up_q got %h exp 000", bus.q); end
      drive(0, 1, 0, 0, 12'h000, 1);
      #1;
      n_chk++; if (bus.min !== 1'b1) begin n_fail++; $display("FAIL sat_min got %b exp 1", bus.min); end
      tick();
      n_chk++; if (bus.q !== 12'h000) begin n_fail++; $display("FAIL sat_down_q got %h exp 000", bus.q); end
      drive(0, 0, 0, 1, 12'h499, 1);
      tick();
      drive(1, 0, 0, 0, 12'h000, 1);
      #1;
      n_chk++; if (bus.max !== 1'b1 || bus.min !== 1'b0) begin n_fail++; $display("FAIL sat_max got %b%b exp 10", bus.max, bus.min); end
      tick();
      n_chk++; if (bus.q !== 12'h499) begin n_fail++; $display("FAIL sat_up_q got %h exp 499", bus.q); end
      drive(0, 1, 0, 0, 12'h000, 1);
      tick();
      n_chk++; if (bus.q !== 12'h498) begin n_fail++; $display("FAIL sat_dec_q got %h exp 498", bus.q); end
   endtask
   task automatic test_ripple;
      drive(0, 0, 0, 1, 12'h099, 0);
      tick();
      n_chk++; if (bus.q !== 12'h099) begin n_fail++; $display("FAIL rip_load got %h exp 099", bus.q); end
      drive(1, 0, 0, 0, 12'h000, 0);
      tick();
      n_chk++; if (bus.q !== 12'h100) begin n_fail++; $display("FAIL rip_up got %h exp 100", bus.q); end
      drive(0, 1, 0, 0, 12'h000, 0);
      tick();
      n_chk++; if (bus.q !== 12'h099) begin n_fail++; $display("FAIL rip_down got %h exp 099", bus.q); end
      drive(0, 0, 0, 1, 12'h190, 0);
      tick();
      drive(0, 1, 0, 0, 12'h000, 0);
      repeat (91) tick();
      n_chk++; if (bus.q !== 12'h099) begin n_fail++; $display("FAIL rip_down91 got %h exp 099", bus.q); end
   endtask
   task automatic test_load;
      drive(0, 0, 0, 1, 12'h372, 0);
      tick();
      n_chk++; if (bus.q !== 12'h372 || bus.load_err !== 1'b0) begin n_fail++; $display("FAIL ld_ok got %h/%b exp 372/0", bus.q, bus.load_err); end
      drive(0, 0, 0, 1, 12'h3A2, 0);
      tick();
      n_chk++; if (bus.q !== 12'h372 || bus.load_err !== 1'b1) begin n_fail++; $display("FAIL ld_digit got %h/%b exp 372/1", bus.q, bus.load_err); end
      drive(1, 0, 0, 0, 12'h000, 0);
      tick();
      n_chk++; if (bus.q !== 12'h373 || bus.load_err !== 1'b1) begin n_fail++; $display("FAIL ld_err_hold got %h/%b exp 373/1", bus.q, bus.load_err); end
      drive(0, 0, 0, 1, 12'h500, 0);
      tick();
      n_chk++; if (bus.q !== 12'h373 || bus.load_err !== 1'b1) begin n_fail++; $display("FAIL ld_limit got %h/%b exp 373/1", bus.q, bus.load_err); end
      drive(0, 0, 0, 1, 12'h123, 0);
      tick();
      n_chk++; if (bus.q !== 12'h123 || bus.load_err !== 1'b0) begin n_fail++; $display("FAIL ld_recover got %h/%b exp 123/0", bus.q, bus.load_err); end
      drive(0, 0, 0, 1, 12'h0F0, 0);
      tick();
      drive(0, 0, 1, 0, 12'h000, 0);
      tick();
      n_chk++; if (bus.q !== 12'h000 || bus.load_err !== 1'b0) begin n_fail++; $display("FAIL ld_clr got %h/%b exp 000/0", bus.q, bus.load_err); end
   endtask
   task automatic test_priority;
      drive(0, 0, 0, 1, 12'h499, 0);
      tick();
      drive(1, 0, 1, 1, 12'h123, 0);
      #1;
      n_chk++; if (bus.max !== 1'b0) begin n_fail++; $display("FAIL pri_clr_max got %b exp 0", bus.max); end
      tick();
      n_chk++; if (bus.q !== 12'h000) begin n_fail++; $display("FAIL pri_clr_q got %h exp 000", bus.q); end
      drive(0, 0, 0, 1, 12'h499, 0);
      tick();
      drive(1, 0, 0, 1, 12'h250, 0);
      #1;
      n_chk++; if (bus.max !== 1'b0) begin n_fail++; $display("FAIL pri_ld_max got %b exp 0", bus.max); end
      tick();
      n_chk++; if (bus.q !== 12'h250) begin n_fail++; $display("FAIL pri_ld_q got %h exp 250", bus.q); end
      drive(1, 1, 0, 0, 12'h000, 0);
      tick();
      n_chk++; if (bus.q !== 12'h250) begin n_fail++; $display("FAIL pri_hold_q got %h exp 250", bus.q); end
      drive(0, 0, 1, 0, 12'h000, 0);
      tick();
      drive(1, 1, 0, 0, 12'h000, 0);
      #1;
      n_chk++; if (bus.max !== 1'b0 || bus.min !== 1'b0) begin n_fail++; $display("FAIL pri_hold_mm got %b%b exp 00", bus.max, bus.min); end
      tick();
      n_chk++; if (bus.q !== 12'h000) begin n_fail++; $display("FAIL pri_hold0_q got %h exp 000", bus.q); end
   endtask
   task automatic test_async_reset;
      drive(0, 0, 0, 1, 12'h257, 0);
      tick();
      drive(0, 0, 0, 1, 12'hA00, 0);
      tick();
      drive(1, 0, 0, 0, 12'h000, 0);
      n_chk++; if (bus.q !== 12'h257 || bus.load_err !== 1'b1) begin n_fail++; $display("FAIL ar_pre got %h/%b exp 257/1", bus.q, bus.load_err); end
      #2;
      RSTN = 1'b0;
      #1;
      n_chk++; if (bus.q !== 12'h000 || bus.load_err !== 1'b0) begin n_fail++; $display("FAIL ar_async got %h/%b exp 000/0", bus.q, bus.load_err); end
      tick();
      n_chk++; if (bus.q !== 12'h000) begin n_fail++; $display("FAIL ar_held got %h exp 000", bus.q); end
      @(negedge CLK);
      RSTN = 1'b1;
      tick();
      n_chk++; if (bus.q !== 12'h001) begin n_fail++; $display("FAIL ar_resume1 got %h exp 001", bus.q); end
      tick();
      n_chk++; if (bus.q !== 12'h002) begin n_fail++; $display("FAIL ar_resume2 got %h exp 002", bus.q); end
   endtask
   initial begin
      test_reset();
      test_count_up();
      test_wrap_sat();
      test_ripple();
      test_load();
      test_priority();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bcd_updown_cnt.md
# bcd_updown_cnt

Parametrised multi-digit BCD up/down counter with synchronous load, clear, selectable wrap/saturate mode and combinational terminal-count outputs for cascading. It generalises the single-digit decade counter to DIGITS BCD digits with an arbitrary terminal value LIMIT (e.g. 0–499 for a 500-state timer). It sits in timer and display datapaths, drives 7-segment decoders digit-by-digit, and chains to further stages through max/min.

## Interface
- DIGITS, 3, number of BCD digits; q width = 4*DIGITS; legal 1..8
- LIMIT, 499, terminal count as a decimal integer; legal 1..10^DIGITS-1; counter range 0..LIMIT
- CLK  in  1  clock, all state updates on rising edge
- RSTN  in  1  asynchronous active-low reset
- inc  in  1  count-up request, one step per cycle
- dec  in  1  count-down request, one step per cycle
- clr  in  1  synchronous clear to 0
- load  in  1  synchronous load of load_val
- load_val  in  4*DIGITS  BCD value to load; digit k at bits [4k+3:4k], digit 0 least significant
- sat  in  1  0 = wrap at LIMIT/0, 1 = saturate at LIMIT/0
- q  out  4*DIGITS  current BCD count, registered
- max  out  1  combinational: up-step at terminal this cycle
- min  out  1  combinational: down-step at zero this cycle
- load_err  out  1  registered: last load request was rejected

## Operation
- Reset (RSTN low, asynchronous): q = 0, load_err = 0; max/min follow their equations from q = 0.
- Per-cycle priority: clr > load > step. Effective step: up = inc & ~dec, down = dec & ~inc; inc & dec together = hold.
- clr: q <- 0; load_err <- 0.
- load (clr low): accepted iff every digit of load_val ≤ 9 and its decimal value ≤ LIMIT → q <- load_val, load_err <- 0; otherwise q unchanged, load_err <- 1.
- load_err holds its value until next clr, load or reset; steps do not change it.
- up: q < LIMIT → q + 1 in BCD (digit 9 → 0 with carry into next digit); q = LIMIT → 0 if sat = 0, stays LIMIT if sat = 1.
- down: q > 0 → q − 1 in BCD (digit 0 → 9 with borrow from next digit); q = 0 → LIMIT if sat = 0, stays 0 if sat = 1.
- max = up & (q == LIMIT) & ~clr & ~load, independent of sat.
- min = down & (q == 0) & ~clr & ~load, independent of sat.
- max and min are never high together; neither asserts on a hold cycle.
- Every digit of q is always 0..9 and q's value is always 0..LIMIT; no reachable illegal state.
- LIMIT converted to BCD at elaboration; no runtime binary↔BCD conversion.

## Timing
- q, load_err: registered, update one cycle after the qualifying input is sampled.
- max, min: combinational from current q and inputs, valid in the same cycle as the step; intended as inc/dec of the next cascaded stage.
- Full ripple across all DIGITS digits (e.g. 099 → 100, 100 → 099) completes in a single cycle.
- RSTN assertion mid-operation clears q immediately, regardless of CLK; deassertion is synchronised externally.
- No multi-cycle operations; every request accepted or rejected in the cycle it is presented.

## Test plan
- Reset and count up: RSTN pulse, then inc = 1 for 500 cycles, sat = 0, DIGITS = 3, LIMIT = 499 → q steps 000, 001 … 009, 010 … 499, 000; max high only during the cycle q = 499.
- Count down wrap and saturate: from q = 000, dec = 1, sat = 0 → min high, next q = 499; sat = 1 → min high, q stays 000; from q = 499 with inc, sat = 1 → max high, q stays 499.
- Digit ripple: load 099 then inc → q = 100; dec → q = 099; load 190 then dec ×91 → q = 099.
- Load checks: load 0x372 → q = 372, load_err = 0; load 0x3A2 (digit > 9) → q unchanged, load_err = 1; load 0x500 (> LIMIT) → q unchanged, load_err = 1; clr → q = 000, load_err = 0.
- Priority/simultaneity: clr & load & inc same cycle → q = 000, max = 0; load & inc at q = 499 → loaded value, max = 0; inc & dec together → q holds, max = min = 0.
- Async reset mid-count: q = 257, drop RSTN between edges → q = 000 before next CLK edge; counting resumes from 000 after release.
